// File: rtl/switch_mcu_ahb_pkg.sv
// Shared definitions for the switch MCU AHB-Lite arbiter.
//   - AHB transfer-type, burst and size encodings
//   - master index constants (instruction fetch / load-store)
//   - arbiter sequencer state encoding
package switch_mcu_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HSIZE_WORD    = 4'd2;

    localparam logic M_IFU = 1'b0;
    localparam logic M_LSU = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_t;

endpackage

// File: rtl/switch_mcu_arb_sel.sv
// Combinational winner select for the two-master AHB arbiter.
//   req        : per-master request (bit N = master N has htrans != 0)
//   last_grant : master granted most recently (also the lock owner)
//   lock       : lock bit latched at the most recent grant
//   any_req    : at least one master requests
//   winner     : index of the master to grant next
// Build option: ARB_RR_EN selects round-robin on simultaneous requests;
// without it the HI_PRI master wins ties.
module switch_mcu_arb_sel
    import switch_mcu_ahb_pkg::*;
#(
    parameter logic HI_PRI = 1'b1
) (
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       lock,
    output logic       any_req,
    output logic       winner
);

    always_comb begin
        any_req = |req;
        winner  = M_IFU;
        if (lock && req[last_grant]) begin
            // A locked sequence keeps the bus as long as its owner asks.
            winner = last_grant;
        end else if (req == 2'b11) begin
`ifdef ARB_RR_EN
            winner = ~last_grant;
`else
            winner = HI_PRI;
`endif
        end else if (req[M_LSU]) begin
            winner = M_LSU;
        end else begin
            winner = M_IFU;
        end
    end

endmodule

// File: rtl/switch_mcu_ahb_arb.sv
// Two-master AHB-Lite arbiter / sequencer for the switch core system bus.
// Master 0 = instruction fetch, master 1 = load/store. Single transfers,
// one outstanding transfer. Sequencer IDLE -> ADDR -> DATA -> IDLE, all
// outputs registered.
// Ports:
//   in_clk, in_rst            clock, synchronous active-high reset
//   in_mN_*                   master N address/control/write data
//   out_mN_hready/hresp/hrdata response routed only to the granted master
//   in_hready/hresp/hrdata    slave response
//   out_h*                    shared bus address/control/write data
//   out_grant, out_busy       current owner, transfer in flight
//   out_err_cnt               saturating count of error responses
//   out_state                 sequencer state (debug)
// Build option: ARB_RR_EN enables round-robin tie-break (see arb_sel).
//
// Handshake: a master requests by holding htrans != 0 with stable
// address/control/wdata until it sees a one-cycle hready pulse on its own
// out_mN_hready; the slave completes a phase when in_hready=1 at a rising edge.
module switch_mcu_ahb_arb
    import switch_mcu_ahb_pkg::*;
#(
    parameter int   ADDR_W = 32,
    parameter int   DATA_W = 32,
    parameter logic HI_PRI = 1'b1
) (
    input  logic              in_clk,
    input  logic              in_rst,
    input  logic [1:0]        in_m0_htrans,
    input  logic [ADDR_W-1:0] in_m0_haddr,
    input  logic              in_m0_hwrite,
    input  logic [3:0]        in_m0_hsize,
    input  logic [3:0]        in_m0_hport,
    input  logic              in_m0_hmastlock,
    input  logic [DATA_W-1:0] in_m0_hwdata,
    input  logic [1:0]        in_m1_htrans,
    input  logic [ADDR_W-1:0] in_m1_haddr,
    input  logic              in_m1_hwrite,
    input  logic [3:0]        in_m1_hsize,
    input  logic [3:0]        in_m1_hport,
    input  logic              in_m1_hmastlock,
    input  logic [DATA_W-1:0] in_m1_hwdata,
    output logic              out_m0_hready,
    output logic              out_m0_hresp,
    output logic [DATA_W-1:0] out_m0_hrdata,
    output logic              out_m1_hready,
    output logic              out_m1_hresp,
    output logic [DATA_W-1:0] out_m1_hrdata,
    input  logic              in_hready,
    input  logic              in_hresp,
    input  logic [DATA_W-1:0] in_hrdata,
    output logic [ADDR_W-1:0] out_haddr,
    output logic [1:0]        out_htrans,
    output logic              out_hwrite,
    output logic [3:0]        out_hsize,
    output logic [2:0]        out_hburst,
    output logic [3:0]        out_hport,
    output logic              out_hmastlock,
    output logic [DATA_W-1:0] out_hwdata,
    output logic              out_grant,
    output logic              out_busy,
    output logic [7:0]        out_err_cnt,
    output logic [1:0]        out_state
);

    arb_state_t state, state_nxt;
    logic       any_req, winner;
    logic       lock_q, lock_nxt, grant_nxt;

    logic [ADDR_W-1:0] haddr_nxt;
    logic [1:0]        htrans_nxt;
    logic              hwrite_nxt, hmastlock_nxt, busy_nxt;
    logic [3:0]        hsize_nxt, hport_nxt;
    logic [DATA_W-1:0] hwdata_nxt, m0_hrdata_nxt, m1_hrdata_nxt;
    logic              m0_hready_nxt, m1_hready_nxt, m0_hresp_nxt, m1_hresp_nxt;
    logic [7:0]        err_cnt_nxt;

    // out_grant doubles as the last-grant / lock-owner register.
    switch_mcu_arb_sel #(.HI_PRI(HI_PRI)) u_sel (
        .req        ({in_m1_htrans != HTRANS_IDLE, in_m0_htrans != HTRANS_IDLE}),
        .last_grant (out_grant),
        .lock       (lock_q),
        .any_req    (any_req),
        .winner     (winner)
    );

    assign out_hburst = HBURST_SINGLE;
    assign out_state  = state;

    // State and registered outputs.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state         <= IDLE;
            out_grant     <= HI_PRI;
            lock_q        <= 1'b0;
            out_haddr     <= '0;
            out_htrans    <= HTRANS_IDLE;
            out_hwrite    <= 1'b0;
            out_hsize     <= '0;
            out_hport     <= '0;
            out_hmastlock <= 1'b0;
            out_hwdata    <= '0;
            out_busy      <= 1'b0;
            out_m0_hready <= 1'b0;
            out_m1_hready <= 1'b0;
            out_m0_hresp  <= 1'b0;
            out_m1_hresp  <= 1'b0;
            out_m0_hrdata <= '0;
            out_m1_hrdata <= '0;
            out_err_cnt   <= '0;
        end else begin
            state         <= state_nxt;
            out_grant     <= grant_nxt;
            lock_q        <= lock_nxt;
            out_haddr     <= haddr_nxt;
            out_htrans    <= htrans_nxt;
            out_hwrite    <= hwrite_nxt;
            out_hsize     <= hsize_nxt;
            out_hport     <= hport_nxt;
            out_hmastlock <= hmastlock_nxt;
            out_hwdata    <= hwdata_nxt;
            out_busy      <= busy_nxt;
            out_m0_hready <= m0_hready_nxt;
            out_m1_hready <= m1_hready_nxt;
            out_m0_hresp  <= m0_hresp_nxt;
            out_m1_hresp  <= m1_hresp_nxt;
            out_m0_hrdata <= m0_hrdata_nxt;
            out_m1_hrdata <= m1_hrdata_nxt;
            out_err_cnt   <= err_cnt_nxt;
        end
    end

    // Next state.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req)   state_nxt = ADDR;
            ADDR:    if (in_hready) state_nxt = DATA;
            DATA:    if (in_hready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        grant_nxt     = out_grant;
        lock_nxt      = lock_q;
        haddr_nxt     = out_haddr;
        htrans_nxt    = out_htrans;
        hwrite_nxt    = out_hwrite;
        hsize_nxt     = out_hsize;
        hport_nxt     = out_hport;
        hmastlock_nxt = out_hmastlock;
        hwdata_nxt    = out_hwdata;
        busy_nxt      = out_busy;
        m0_hready_nxt = 1'b0;
        m1_hready_nxt = 1'b0;
        m0_hresp_nxt  = out_m0_hresp;
        m1_hresp_nxt  = out_m1_hresp;
        m0_hrdata_nxt = out_m0_hrdata;
        m1_hrdata_nxt = out_m1_hrdata;
        err_cnt_nxt   = out_err_cnt;
        case (state)
            IDLE: begin
                haddr_nxt     = '0;
                htrans_nxt    = HTRANS_IDLE;
                hwrite_nxt    = 1'b0;
                hsize_nxt     = '0;
                hport_nxt     = '0;
                hmastlock_nxt = 1'b0;
                hwdata_nxt    = '0;
                busy_nxt      = 1'b0;
                if (any_req) begin
                    grant_nxt     = winner;
                    lock_nxt      = winner ? in_m1_hmastlock : in_m0_hmastlock;
                    haddr_nxt     = winner ? in_m1_haddr     : in_m0_haddr;
                    htrans_nxt    = HTRANS_NONSEQ;
                    hwrite_nxt    = winner ? in_m1_hwrite    : in_m0_hwrite;
                    hsize_nxt     = winner ? in_m1_hsize     : in_m0_hsize;
                    hport_nxt     = winner ? in_m1_hport     : in_m0_hport;
                    hmastlock_nxt = winner ? in_m1_hmastlock : in_m0_hmastlock;
                    busy_nxt      = 1'b1;
                end
            end
            ADDR: begin
                if (in_hready) begin
                    htrans_nxt = HTRANS_IDLE;
                    haddr_nxt  = '0;
                    hwdata_nxt = out_grant ? in_m1_hwdata : in_m0_hwdata;
                end
            end
            DATA: begin
                if (in_hready) begin
                    if (out_grant) begin
                        m1_hready_nxt = 1'b1;
                        m1_hresp_nxt  = in_hresp;
                        m1_hrdata_nxt = in_hrdata;
                    end else begin
                        m0_hready_nxt = 1'b1;
                        m0_hresp_nxt  = in_hresp;
                        m0_hrdata_nxt = in_hrdata;
                    end
                    if (in_hresp && out_err_cnt != 8'hFF) begin
                        err_cnt_nxt = out_err_cnt + 8'd1;
                    end
                    // Leave the bus clean for the following IDLE cycle.
                    hwrite_nxt    = 1'b0;
                    hsize_nxt     = '0;
                    hport_nxt     = '0;
                    hmastlock_nxt = 1'b0;
                    hwdata_nxt    = '0;
                    busy_nxt      = 1'b0;
                end
            end
            default: ;
        endcase
    end

endmodule
